// File: rtl/alu_seq.sv
// Multi-cycle RV32 execute unit: single-cycle ALU ops plus iterative MUL/DIV.
// Define ALU_SEQ_MULDIV_EN to build the M-extension datapath (ops 10-15).
module alu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SRA  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SRL  = 4'd4;
    localparam logic [3:0] OP_AND  = 4'd5;
    localparam logic [3:0] OP_OR   = 4'd6;
    localparam logic [3:0] OP_SLT  = 4'd7;
    localparam logic [3:0] OP_SLTU = 4'd8;
    localparam logic [3:0] OP_XOR  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_MULH = 4'd11;
    localparam logic [3:0] OP_DIV  = 4'd12;
    localparam logic [3:0] OP_DIVU = 4'd13;
    localparam logic [3:0] OP_REM  = 4'd14;
    localparam logic [3:0] OP_REMU = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            zero_q, zero_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] simple_res;
    logic [SHW-1:0]  shamt;
    logic            is_md;

    assign shamt = b[SHW-1:0];
    assign is_md = (op >= OP_MUL);

    always_comb begin
        simple_res = '0;
        unique case (op)
            OP_ADD:  simple_res = a + b;
            OP_SUB:  simple_res = a - b;
            OP_SRA:  simple_res = XLEN'($signed(a) >>> shamt);
            OP_SLL:  simple_res = a << shamt;
            OP_SRL:  simple_res = a >> shamt;
            OP_AND:  simple_res = a & b;
            OP_OR:   simple_res = a | b;
            OP_SLT:  simple_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: simple_res = {{(XLEN-1){1'b0}}, a < b};
            OP_XOR:  simple_res = a ^ b;
            default: simple_res = '0;
        endcase
    end

`ifdef ALU_SEQ_MULDIV_EN
    // hi/lo/mc hold product-acc/multiplier/multiplicand or rem/quot/divisor
    logic [XLEN-1:0]   hi, hi_d, lo, lo_d, mc, mc_d;
    logic [SHW-1:0]    cnt, cnt_d;
    logic [3:0]        op_q, op_qd;
    logic              neg, neg_d;
    logic [XLEN-1:0]   hi_s, lo_s;
    logic [XLEN:0]     msum;
    logic [XLEN-1:0]   rem_sh;
    logic              ge;
    logic [2*XLEN-1:0] prod, prod_f;
    logic [XLEN-1:0]   md_res;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic              sa, sb, is_mul;

    assign sa    = a[XLEN-1];
    assign sb    = b[XLEN-1];
    assign abs_a = sa ? -a : a;
    assign abs_b = sb ? -b : b;
    assign is_mul = (op_q == OP_MUL) || (op_q == OP_MULH);

    always_comb begin
        msum   = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
        rem_sh = {hi[XLEN-2:0], lo[XLEN-1]};
        ge     = ({hi[XLEN-1], rem_sh} >= {1'b0, mc});
        if (is_mul) begin
            hi_s = msum[XLEN:1];
            lo_s = {msum[0], lo[XLEN-1:1]};
        end else if (ge) begin
            hi_s = rem_sh - mc;
            lo_s = {lo[XLEN-2:0], 1'b1};
        end else begin
            hi_s = rem_sh;
            lo_s = {lo[XLEN-2:0], 1'b0};
        end
    end

    always_comb begin
        prod   = {hi_s, lo_s};
        prod_f = neg ? -prod : prod;
        md_res = '0;
        unique case (op_q)
            OP_MUL:          md_res = prod_f[XLEN-1:0];
            OP_MULH:         md_res = prod_f[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU: md_res = neg ? -lo_s : lo_s;
            OP_REM, OP_REMU: md_res = neg ? -hi_s : hi_s;
            default:         md_res = '0;
        endcase
    end
`endif

    always_comb begin
        state_d = state;
        res_d   = res_q;
        zero_d  = zero_q;
        ill_d   = ill_q;
`ifdef ALU_SEQ_MULDIV_EN
        hi_d  = hi;
        lo_d  = lo;
        mc_d  = mc;
        cnt_d = cnt;
        op_qd = op_q;
        neg_d = neg;
`endif
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_md) begin
`ifdef ALU_SEQ_MULDIV_EN
                        state_d = BUSY;
                        cnt_d   = SHW'(XLEN-1);
                        op_qd   = op;
                        hi_d    = '0;
                        unique case (op)
                            OP_MUL: begin
                                mc_d  = a;
                                lo_d  = b;
                                neg_d = 1'b0;
                            end
                            OP_MULH: begin
                                mc_d  = abs_a;
                                lo_d  = abs_b;
                                neg_d = sa ^ sb;
                            end
                            OP_DIV: begin
                                lo_d  = abs_a;
                                mc_d  = abs_b;
                                neg_d = (sa ^ sb) && (b != '0);
                            end
                            OP_REM: begin
                                lo_d  = abs_a;
                                mc_d  = abs_b;
                                neg_d = sa;
                            end
                            default: begin
                                lo_d  = a;
                                mc_d  = b;
                                neg_d = 1'b0;
                            end
                        endcase
`else
                        state_d = DONE;
                        res_d   = '0;
                        zero_d  = 1'b1;
                        ill_d   = 1'b1;
`endif
                    end else begin
                        state_d = DONE;
                        res_d   = simple_res;
                        zero_d  = (simple_res == '0);
                        ill_d   = 1'b0;
                    end
                end
            end
            BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
                hi_d  = hi_s;
                lo_d  = lo_s;
                cnt_d = cnt - 1'b1;
                if (cnt == '0) begin
                    state_d = DONE;
                    res_d   = md_res;
                    zero_d  = (md_res == '0);
                    ill_d   = 1'b0;
                end
`else
                state_d = IDLE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            res_q  <= '0;
            zero_q <= 1'b1;
            ill_q  <= 1'b0;
        end else begin
            state  <= state_d;
            res_q  <= res_d;
            zero_q <= zero_d;
            ill_q  <= ill_d;
        end
    end

`ifdef ALU_SEQ_MULDIV_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi   <= '0;
            lo   <= '0;
            mc   <= '0;
            cnt  <= '0;
            op_q <= '0;
            neg  <= 1'b0;
        end else begin
            hi   <= hi_d;
            lo   <= lo_d;
            mc   <= mc_d;
            cnt  <= cnt_d;
            op_q <= op_qd;
            neg  <= neg_d;
        end
    end
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = res_q;
    assign zero      = zero_q;
    assign illegal   = ill_q;

endmodule
